// File: rtl/button_debouncer_pkg.sv
// button_debouncer_pkg
//   Shared constants and helpers for the button debouncer.
//   - DEF_STABLE_SAMPLES : consecutive identical samples needed to accept a level
//   - DEF_REPEAT_DELAY   : samples after acceptance before the first auto-repeat
//   - DEF_REPEAT_RATE    : samples between later auto-repeats
//   - cnt_width(n)       : ceil(log2(n)), minimum 1; enough bits to hold 0..n-1
package button_debouncer_pkg;

  localparam int DEF_STABLE_SAMPLES = 4;
  localparam int DEF_REPEAT_DELAY   = 30;
  localparam int DEF_REPEAT_RATE    = 6;

  function automatic int cnt_width(input int n);
    int w;
    for (w = 1; (1 << w) < n; w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/button_debouncer_debounce_channel.sv
// debounce_channel
//   One debounced input: 2-flop synchroniser, optional inversion, stability
//   counter, level register and one-cycle press/release strobes. With
//   BUTTON_DEBOUNCER_AUTOREPEAT_EN defined it also carries a repeat counter
//   that re-fires the press strobe while the level is held high.
// Ports:
//   clock_i      main clock
//   rst_ni       asynchronous active-low reset
//   sample_en_i  one-cycle sampling enable shared by all channels
//   raw_i        asynchronous raw input
//   debounced_o  filtered level, active-high
//   pressed_o    one-cycle strobe on accepted 0->1 (and auto-repeat)
//   released_o   one-cycle strobe on accepted 1->0
// STABLE_SAMPLES must lie in 2..255.
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter bit INVERT         = 1'b0,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
  input  logic clock_i,
  input  logic rst_ni,
  input  logic sample_en_i,
  input  logic raw_i,
  output logic debounced_o,
  output logic pressed_o,
  output logic released_o
);

  localparam int            CW       = cnt_width(STABLE_SAMPLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          s;
  logic          differ;
  logic          at_last;
  logic          accept;
  logic          rpt_fire;

  assign s       = sync_q[1] ^ INVERT;
  assign differ  = s ^ level_q;
  assign at_last = (cnt_q == CNT_LAST);
  // Level flips on this sample.
  assign accept  = sample_en_i & differ & at_last;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (sample_en_i) begin
      if (!differ) begin
        cnt_d = '0;
      end else if (at_last) begin
        cnt_d   = '0;
        level_d = ~level_q;
        press_d = ~level_q;
        rel_d   = level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (rpt_fire) begin
        press_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  // Counts samples while the level stays high. On reaching REPEAT_DELAY it
  // fires, then it oscillates between REPEAT_DELAY and REPEAT_DELAY+REPEAT_RATE
  // so every later hit on the upper value is one repeat period.
  localparam int RW = cnt_width(REPEAT_DELAY + REPEAT_RATE + 1);

  logic [RW-1:0] rpt_q, rpt_d, rpt_inc;

  always_comb begin
    rpt_d    = rpt_q;
    rpt_fire = 1'b0;
    rpt_inc  = rpt_q + RW'(1);
    if (sample_en_i) begin
      if (level_q && !accept) begin
        rpt_d = rpt_inc;
        if (rpt_inc == RW'(REPEAT_DELAY)) begin
          rpt_fire = 1'b1;
        end else if (rpt_inc == RW'(REPEAT_DELAY + REPEAT_RATE)) begin
          rpt_fire = 1'b1;
          rpt_d    = RW'(REPEAT_DELAY);
        end
      end else begin
        // Level low, or changing on this sample (press restarts, release clears).
        rpt_d = '0;
      end
    end
  end

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`else
  // No repeat logic in this build; the repeat timing only appears in an
  // expression that is always false.
  assign rpt_fire = (REPEAT_DELAY < 0) && (REPEAT_RATE < 0);
`endif

  assign debounced_o = level_q;
  assign pressed_o   = press_q;
  assign released_o  = rel_q;

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer
//   Debounces WIDTH raw buttons in the main clock domain. The slow divider
//   wave tick_in is only edge-detected into a sampling enable, never used as
//   a clock. Optional auto-repeat: define BUTTON_DEBOUNCER_AUTOREPEAT_EN.
// Ports:
//   clock          main clock
//   reset          asynchronous active-low reset
//   tick_in        debouncing-rate square wave (register output, same domain)
//   raw[W]         asynchronous raw inputs
//   debounced[W]   filtered levels, active-high
//   pressed[W]     one-cycle strobes on accepted press (and auto-repeat)
//   released[W]    one-cycle strobes on accepted release
//   sample_strobe  one-cycle pulse per sampling instant, aligned with strobes
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter bit INVERT         = 1'b0,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_in,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] released,
  output logic             sample_strobe
);

  logic tick_d_q;
  logic sample_strobe_q;
  logic sample_en;

  // Rising edge of the slow wave; tick_in is already synchronous to clock.
  assign sample_en = tick_in & ~tick_d_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_d_q        <= 1'b0;
      sample_strobe_q <= 1'b0;
    end else begin
      tick_d_q        <= tick_in;
      sample_strobe_q <= sample_en;
    end
  end

  assign sample_strobe = sample_strobe_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .INVERT        (INVERT),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE)
    ) u_ch (
      .clock_i    (clock),
      .rst_ni     (reset),
      .sample_en_i(sample_en),
      .raw_i      (raw[i]),
      .debounced_o(debounced[i]),
      .pressed_o  (pressed[i]),
      .released_o (released[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer
//   Bench for button_debouncer (WIDTH=4, STABLE_SAMPLES=4, tick period 16
//   clocks). Strobe events are tagged with the sampling-instant number at which
//   they appear; expected events go into exp_q when stimulus is driven.
//   Build with +define+BUTTON_DEBOUNCER_AUTOREPEAT_EN to include the repeat test.
module tb_button_debouncer;

  localparam int W  = 4;
  localparam int EW = 16 + 1 + W + W;

  logic         clock     = 1'b0;
  logic         reset     = 1'b0;
  logic         tick_in;
  logic         tick_hold = 1'b0;
  logic [W-1:0] raw       = '0;
  logic [W-1:0] debounced;
  logic [W-1:0] pressed;
  logic [W-1:0] released;
  logic         sample_strobe;

  int checks     = 0;
  int errors     = 0;
  int sample_cnt = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_ev;
  logic [EW-1:0] exp_ev;

  button_debouncer dut (
    .clock        (clock),
    .reset        (reset),
    .tick_in      (tick_in),
    .raw          (raw),
    .debounced    (debounced),
    .pressed      (pressed),
    .released     (released),
    .sample_strobe(sample_strobe)
  );

  // ---------------- clock / tick ----------------
  initial forever #5 clock = ~clock;

  initial begin
    tick_in = 1'b0;
    forever begin
      repeat (8) @(negedge clock);
      if (!tick_hold) tick_in = ~tick_in;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (reset && sample_strobe) sample_cnt = sample_cnt + 1;
    if ((pressed | released) != '0) begin
      obs_ev = {sample_cnt[15:0], sample_strobe, pressed, released};
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL strobe_unexpected: got sample=%0d ss=%b pressed=%b released=%b, expected no strobe",
                 sample_cnt, sample_strobe, pressed, released);
      end else begin
        exp_ev = exp_q.pop_front();
        if (obs_ev !== exp_ev) begin
          errors = errors + 1;
          $display("FAIL strobe_event: got sample=%0d ss=%b p=%b r=%b, expected sample=%0d ss=%b p=%b r=%b",
                   obs_ev[24:9], obs_ev[8], obs_ev[7:4], obs_ev[3:0],
                   exp_ev[24:9], exp_ev[8], exp_ev[7:4], exp_ev[3:0]);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [EW-1:0] mk_ev(input int tag, input logic [W-1:0] p,
                                          input logic [W-1:0] r);
    return {tag[15:0], 1'b1, p, r};
  endfunction

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_samples(input int target);
    int guard;
    guard = 0;
    while (sample_cnt < target && guard < 1200) begin
      step();
      guard++;
    end
    if (sample_cnt < target) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL sample_timeout: got sample=%0d, expected sample=%0d", sample_cnt, target);
    end
  endtask

  // Assert reset, then release it just after the tick falls so the first
  // sample comes 8 clocks later with the synchroniser settled.
  task automatic apply_reset(input logic [W-1:0] raw_v);
    int guard;
    reset = 1'b0;
    raw   = raw_v;
    repeat (3) step();
    guard = 0;
    while (tick_in !== 1'b1 && guard < 100) begin step(); guard++; end
    while (tick_in !== 1'b0 && guard < 100) begin step(); guard++; end
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int c;
    reset = 1'b0;
    raw   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      checks = checks + 1;
      if ({debounced, pressed, released, sample_strobe} !== '0) begin
        errors = errors + 1;
        $display("FAIL reset_outputs: got deb=%b p=%b r=%b ss=%b, expected all 0",
                 debounced, pressed, released, sample_strobe);
      end
    end
    apply_reset(4'b1111);
    c = sample_cnt;
    exp_q.push_back(mk_ev(c + 4, 4'b1111, 4'b0000));
    wait_samples(c + 3);
    checks = checks + 1;
    if (debounced !== 4'b0000) begin
      errors = errors + 1;
      $display("FAIL reset_early: got deb=%b, expected 0000", debounced);
    end
    wait_samples(c + 5);
    checks = checks + 1;
    if (debounced !== 4'b1111 || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL reset_accept: got deb=%b pending=%0d, expected deb=1111 pending=0",
               debounced, exp_q.size());
    end
  endtask

  task automatic test_clean_press();
    int c;
    apply_reset(4'b0000);
    raw = 4'b0001;
    c = sample_cnt;
    exp_q.push_back(mk_ev(c + 4, 4'b0001, 4'b0000));
    wait_samples(c + 3);
    checks = checks + 1;
    if (debounced !== 4'b0000) begin
      errors = errors + 1;
      $display("FAIL press_early: got deb=%b, expected 0000", debounced);
    end
    wait_samples(c + 4);
    checks = checks + 1;
    if (debounced !== 4'b0001 || pressed !== 4'b0001 || sample_strobe !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL press_accept: got deb=%b p=%b ss=%b, expected deb=0001 p=0001 ss=1",
               debounced, pressed, sample_strobe);
    end
    wait_samples(c + 6);
    checks = checks + 1;
    if (debounced !== 4'b0001 || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL press_hold: got deb=%b pending=%0d, expected deb=0001 pending=0",
               debounced, exp_q.size());
    end
  endtask

  task automatic test_bounce_rejection();
    int   c;
    logic v;
    apply_reset(4'b0000);
    v = 1'b0;
    for (int k = 0; k < 10; k++) begin
      v      = ~v;
      raw[1] = v;
      c      = sample_cnt;
      wait_samples(c + 3);
    end
    checks = checks + 1;
    if (debounced !== 4'b0000) begin
      errors = errors + 1;
      $display("FAIL bounce_level: got deb=%b, expected 0000", debounced);
    end
    raw[1] = 1'b1;
    c = sample_cnt;
    exp_q.push_back(mk_ev(c + 4, 4'b0010, 4'b0000));
    wait_samples(c + 3);
    checks = checks + 1;
    if (debounced !== 4'b0000) begin
      errors = errors + 1;
      $display("FAIL bounce_settle_early: got deb=%b, expected 0000", debounced);
    end
    wait_samples(c + 5);
    checks = checks + 1;
    if (debounced !== 4'b0010 || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL bounce_settle: got deb=%b pending=%0d, expected deb=0010 pending=0",
               debounced, exp_q.size());
    end
  endtask

  task automatic test_simultaneous();
    int c;
    apply_reset(4'b0000);
    raw = 4'b0001;
    c = sample_cnt;
    exp_q.push_back(mk_ev(c + 4, 4'b0001, 4'b0000));
    wait_samples(c + 4);
    raw = 4'b0100;
    c = sample_cnt;
    exp_q.push_back(mk_ev(c + 4, 4'b0100, 4'b0001));
    wait_samples(c + 4);
    checks = checks + 1;
    if (pressed !== 4'b0100 || released !== 4'b0001) begin
      errors = errors + 1;
      $display("FAIL simul_strobes: got p=%b r=%b, expected p=0100 r=0001", pressed, released);
    end
    wait_samples(c + 5);
    checks = checks + 1;
    if (debounced !== 4'b0100 || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL simul_level: got deb=%b pending=%0d, expected deb=0100 pending=0",
               debounced, exp_q.size());
    end
  endtask

  task automatic test_tick_stall();
    int c;
    int bad;
    int guard;
    apply_reset(4'b0000);
    raw = 4'b0110;
    c = sample_cnt;
    exp_q.push_back(mk_ev(c + 4, 4'b0110, 4'b0000));
    wait_samples(c + 5);
    guard = 0;
    while (tick_in !== 1'b1 && guard < 40) begin step(); guard++; end
    tick_hold = 1'b1;
    raw = 4'b1001;
    c   = sample_cnt;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (sample_strobe !== 1'b0 || debounced !== 4'b0110 ||
          pressed !== 4'b0000 || released !== 4'b0000) bad++;
    end
    checks = checks + 1;
    if (bad != 0 || sample_cnt != c) begin
      errors = errors + 1;
      $display("FAIL stall_hold: got %0d bad cycles, %0d samples, expected 0 bad cycles, 0 samples",
               bad, sample_cnt - c);
    end
    tick_hold = 1'b0;
    exp_q.push_back(mk_ev(c + 4, 4'b1001, 4'b0110));
    wait_samples(c + 5);
    checks = checks + 1;
    if (debounced !== 4'b1001 || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL stall_resume: got deb=%b pending=%0d, expected deb=1001 pending=0",
               debounced, exp_q.size());
    end
  endtask

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int a;
    apply_reset(4'b0000);
    raw = 4'b1000;
    a = sample_cnt + 4;
    exp_q.push_back(mk_ev(a,      4'b1000, 4'b0000));
    exp_q.push_back(mk_ev(a + 30, 4'b1000, 4'b0000));
    exp_q.push_back(mk_ev(a + 36, 4'b1000, 4'b0000));
    exp_q.push_back(mk_ev(a + 42, 4'b1000, 4'b0000));
    wait_samples(a + 42);
    checks = checks + 1;
    if (pressed !== 4'b1000 || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL repeat_strobes: got p=%b pending=%0d, expected p=1000 pending=0",
               pressed, exp_q.size());
    end
    raw = 4'b0000;
    exp_q.push_back(mk_ev(a + 46, 4'b0000, 4'b1000));
    wait_samples(a + 60);
    checks = checks + 1;
    if (debounced !== 4'b0000 || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL repeat_release: got deb=%b pending=%0d, expected deb=0000 pending=0",
               debounced, exp_q.size());
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_clean_press();
    test_bounce_rejection();
    test_simultaneous();
    test_tick_stall();
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    test_autorepeat();
`endif
    repeat (4) step();
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL final_queue: got %0d pending events, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
